// File: rtl/rc5_round_engine.sv
// rtl/rc5_round_engine.sv - RC5 engine, one half-round per cycle against an external S-table
// Decryption (decrypt port, subtract/rotate-right path) exists only when RC5_DECRYPT_EN is defined.
module rc5_round_engine #(
    parameter int W = 32,
    parameter int R = 12,
    localparam int T  = 2 * R + 2,
    localparam int AW = $clog2(T),
    localparam int RW = $clog2(W)
) (
    input  logic          clk2,
    input  logic          rst,
    input  logic          start,
`ifdef RC5_DECRYPT_EN
    input  logic          decrypt,
`endif
    input  logic [W-1:0]  pt_a,
    input  logic [W-1:0]  pt_b,
    output logic [AW-1:0] s_addr,
    input  logic [W-1:0]  s_data,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  ct_a,
    output logic [W-1:0]  ct_b
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] k;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  a_nxt;
    logic [W-1:0]  b_nxt;
    logic          last;
    logic          low;
`ifdef RC5_DECRYPT_EN
    logic          dec_q;
`endif

    // Rotations via a doubled word so a zero amount passes the word through.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RW-1:0] n);
        logic [2*W-1:0] d;
        d = {x, x} << n;
        return d[2*W-1:W];
    endfunction

`ifdef RC5_DECRYPT_EN
    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [RW-1:0] n);
        logic [2*W-1:0] d;
        d = {x, x} >> n;
        return d[W-1:0];
    endfunction
`endif

    always_comb begin
        state_nxt = state;
        s_addr    = '0;
        a_nxt     = a_q;
        b_nxt     = b_q;
        low       = 1'b0;
        last      = (k == AW'(T - 1));
        busy      = (state != IDLE);
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (last) state_nxt = DONE;
`ifdef RC5_DECRYPT_EN
                s_addr = dec_q ? AW'(T - 1) - k : k;
`else
                s_addr = k;
`endif
                // Entries 0 and 1 are the plain whitening add/subtract.
                low = (s_addr[AW-1:1] == '0);
`ifdef RC5_DECRYPT_EN
                if (dec_q) begin
                    if (s_addr[0]) begin
                        b_nxt = b_q - s_data;
                        if (!low) b_nxt = rotr(b_nxt, a_q[RW-1:0]) ^ a_q;
                    end else begin
                        a_nxt = a_q - s_data;
                        if (!low) a_nxt = rotr(a_nxt, b_q[RW-1:0]) ^ b_q;
                    end
                end else
`endif
                if (!s_addr[0])
                    a_nxt = (low ? a_q : rotl(a_q ^ b_q, b_q[RW-1:0])) + s_data;
                else
                    b_nxt = (low ? b_q : rotl(b_q ^ a_q, a_q[RW-1:0])) + s_data;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The result is captured while leaving DONE, so done lands in the IDLE cycle after busy drops.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            k     <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ct_a  <= '0;
            ct_b  <= '0;
            done  <= 1'b0;
`ifdef RC5_DECRYPT_EN
            dec_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_q   <= pt_a;
                    b_q   <= pt_b;
                    k     <= '0;
`ifdef RC5_DECRYPT_EN
                    dec_q <= decrypt;
`endif
                end
                RUN: begin
                    a_q <= a_nxt;
                    b_q <= b_nxt;
                    k   <= last ? '0 : k + AW'(1);
                end
                DONE: begin
                    ct_a <= a_q;
                    ct_b <= b_q;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/rc5_round_engine.md
RC5_ROUND_ENGINE -- requirements
Module: rc5_round_engine

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning data word width in bits; legal values are 16, 32 and 64.
REQ-002 The block SHALL have parameter R, default 12, meaning number of rounds; legal range is 1..255.
REQ-003 The block SHALL derive localparams T = 2R+2 (S-table entries), AW = ceil(log2(T)) and RW = log2(W).
REQ-004 clk2  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request to process one block; sampled only in IDLE.
REQ-007 decrypt  input  1  mode select, sampled with start: 0 encrypt, 1 decrypt (see REQ-027).
REQ-008 pt_a, pt_b  input  W each  input word pair A/B, sampled when start is accepted.
REQ-009 s_addr  output  AW  S-table index for the current step.
REQ-010 s_data  input  W  S-table word, combinational response to s_addr, used in the same cycle.
REQ-011 busy  output  1  high from the cycle after start is accepted until done.
REQ-012 done  output  1  one-cycle pulse when the result is valid.
REQ-013 ct_a, ct_b  output  W each  result pair, registered.

Function
- REQ-014 The FSM SHALL have states IDLE, RUN and DONE; transitions: IDLE->RUN on start; RUN->DONE when step k = T-1 completes; DONE->IDLE unconditionally.
- REQ-015 On start acceptance, the block SHALL load internal A/B registers from pt_a/pt_b, latch the mode, and clear step counter k to 0.
- REQ-016 In RUN, exactly one half-round SHALL execute per cycle, and k SHALL increment by 1 per cycle; RUN SHALL last exactly T cycles.
- REQ-017 In encrypt mode, s_addr SHALL equal k; in decrypt mode, s_addr SHALL equal T-1-k; s_addr SHALL be 0 outside RUN.
- REQ-018 Encrypt steps, with j = s_addr: j=0 -> A=A+S; j=1 -> B=B+S; even j>=2 -> A=rotl(A^B, B[RW-1:0])+S; odd j>=3 -> B=rotl(B^A, A[RW-1:0])+S.
- REQ-019 Decrypt steps, with j = s_addr: odd j>=3 -> B=rotr(B-S, A[RW-1:0])^A; even j>=2 -> A=rotr(A-S, B[RW-1:0])^B; j=1 -> B=B-S; j=0 -> A=A-S.
- REQ-020 All additions and subtractions SHALL be modulo 2^W; a rotate amount of 0 SHALL leave the word unchanged.
- REQ-021 Latency: when start is accepted at edge N, done SHALL be high during the cycle following edge N+T+1, and ct_a/ct_b SHALL be valid in that same cycle.
- REQ-022 ct_a/ct_b SHALL hold their value from done until the next start acceptance, and SHALL NOT change while busy.
- REQ-023 start SHALL be ignored in RUN and DONE, with no queuing; a start held high through DONE SHALL be accepted in the following IDLE cycle.
- REQ-024 busy and done SHALL never be high in the same cycle.

Reset
- REQ-025 On rst, the block SHALL enter IDLE; k, A, B, ct_a and ct_b SHALL be 0; busy and done SHALL be 0.
- REQ-026 An rst asserted in RUN or DONE SHALL abort the operation; no done pulse SHALL follow, and the first start after rst deasserts SHALL be accepted normally.

Configuration
- REQ-027 The macro RC5_DECRYPT_EN SHALL control decryption:
  - Defined: the decrypt port and REQ-019 SHALL exist.
  - Undefined: the decrypt port SHALL be absent, the block SHALL be encrypt-only, and no subtract/rotr logic SHALL be synthesised.
  - Encrypt timing SHALL be identical in both builds.

Verification
- REQ-028 W=32, R=12, S from an all-zero 16-byte key, pt 00000000/00000000 -> encrypt done 27 cycles after the start edge, ct_a=EEDBA521, ct_b=6D8F4B15.
- REQ-029 (RC5_DECRYPT_EN) Same S, decrypt of EEDBA521/6D8F4B15 -> ct 00000000/00000000; s_addr sequence 25,24,...,0.
- REQ-030 start pulsed again at RUN cycles 3 and 20 -> ignored; exactly one done; result matches REQ-028.
- REQ-031 rst asserted at RUN step k=10, then start with the same pt -> no done from the aborted run; the new run yields the REQ-028 result.
- REQ-032 W=16, R=1, S all zero, pt 0001/0000 -> T=4, done 5 cycles after start, ct matches the behavioural model.
- REQ-033 start held high continuously for 100 cycles -> back-to-back operations, with one IDLE cycle between done and the next busy.
